// File: rtl/sram_arbiter.sv
// Shares one 8-bit asynchronous SRAM between two 16-bit word requesters.
// Each word access becomes two byte cycles on the pins, low byte first.
module sram_arbiter #(
  parameter int WAIT_CYCLES = 3,
  parameter int ADDR_W      = 21
) (
  input  logic              clk50M,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-2:0] addr0,
  input  logic [15:0]       wdata0,
  output logic              ack0,
  output logic [15:0]       rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-2:0] addr1,
  input  logic [15:0]       wdata1,
  output logic              ack1,
  output logic [15:0]       rdata1,
  output logic              busy,
  inout  wire  [7:0]        sram_data,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_ce,
  output logic              sram_we,
  output logic              sram_oe
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] SETUP_LO  = 3'd1;
  localparam logic [2:0] STROBE_LO = 3'd2;
  localparam logic [2:0] HOLD_LO   = 3'd3;
  localparam logic [2:0] SETUP_HI  = 3'd4;
  localparam logic [2:0] STROBE_HI = 3'd5;
  localparam logic [2:0] HOLD_HI   = 3'd6;
  localparam logic [2:0] DONE      = 3'd7;

  localparam int               CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic              port;
  logic              op_we;
  logic              last_grant;
  logic              drive;
  logic [ADDR_W-2:0] op_addr;
  logic [15:0]       op_wdata;
  logic [7:0]        rd_lo;
  logic [7:0]        rd_hi;
  logic [7:0]        dout;

  logic              sel;
  logic              sel_we;
  logic [ADDR_W-2:0] sel_addr;
  logic [15:0]       sel_wdata;

  // On a tie the port that did not win last time is granted.
  assign sel       = (req0 && req1) ? ~last_grant : req1;
  assign sel_we    = sel ? we1 : we0;
  assign sel_addr  = sel ? addr1 : addr0;
  assign sel_wdata = sel ? wdata1 : wdata0;

  assign sram_data = drive ? dout : 8'bz;

  always_ff @(posedge clk50M or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      port       <= 1'b0;
      op_we      <= 1'b0;
      op_addr    <= '0;
      op_wdata   <= '0;
      rd_lo      <= '0;
      rd_hi      <= '0;
      dout       <= '0;
      drive      <= 1'b0;
      last_grant <= 1'b1;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
      busy       <= 1'b0;
      sram_ce    <= 1'b1;
      sram_we    <= 1'b1;
      sram_oe    <= 1'b1;
      sram_addr  <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            port      <= sel;
            op_we     <= sel_we;
            op_addr   <= sel_addr;
            op_wdata  <= sel_wdata;
            busy      <= 1'b1;
            sram_ce   <= 1'b0;
            sram_addr <= {sel_addr, 1'b0};
            dout      <= sel_wdata[7:0];
            drive     <= sel_we;
            state     <= SETUP_LO;
          end
        end
        SETUP_LO, SETUP_HI: begin
          cnt <= '0;
          if (op_we) sram_we <= 1'b0;
          else       sram_oe <= 1'b0;
          state <= (state == SETUP_LO) ? STROBE_LO : STROBE_HI;
        end
        STROBE_LO, STROBE_HI: begin
          if (cnt == CNT_LAST) begin
            sram_we <= 1'b1;
            sram_oe <= 1'b1;
            if (!op_we) begin
              if (state == STROBE_LO) rd_lo <= sram_data;
              else                    rd_hi <= sram_data;
            end
            state <= (state == STROBE_LO) ? HOLD_LO : HOLD_HI;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD_LO: begin
          sram_addr <= {op_addr, 1'b1};
          dout      <= op_wdata[15:8];
          state     <= SETUP_HI;
        end
        HOLD_HI: begin
          sram_ce    <= 1'b1;
          drive      <= 1'b0;
          last_grant <= port;
          if (port) ack1 <= 1'b1;
          else      ack0 <= 1'b1;
          if (!op_we) begin
            if (port) rdata1 <= {rd_hi, rd_lo};
            else      rdata0 <= {rd_hi, rd_lo};
          end
          state <= DONE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized self-checking bench for sram_arbiter against a byte-array SRAM
// model and a word-level reference memory.
module tb_sram_arbiter;

  localparam int W   = 3;
  localparam int LAT = 2 * W + 5;

  logic        clk50M;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [19:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        ack0, ack1, busy;
  logic [15:0] rdata0, rdata1;
  wire  [7:0]  sram_data;
  logic [20:0] sram_addr;
  logic        sram_ce, sram_we, sram_oe;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0]  mem [0:(1<<21)-1];
  logic [7:0]  ref_mem [int];
  logic [19:0] pool [8];
  logic [28:0] wr_log [$];
  int          inv_viol = 0;
  int          we_cnt   = 0;
  int          oe_cnt   = 0;

  sram_arbiter #(.WAIT_CYCLES(W), .ADDR_W(21)) dut (
    .clk50M(clk50M), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .busy(busy), .sram_data(sram_data), .sram_addr(sram_addr),
    .sram_ce(sram_ce), .sram_we(sram_we), .sram_oe(sram_oe)
  );

  initial clk50M = 1'b0;
  always #10 clk50M = ~clk50M;

  // Asynchronous SRAM behaviour: drives on ce&oe, stores while ce&we low.
  assign sram_data = (!sram_ce && !sram_oe) ? mem[sram_addr] : 8'bz;

  always @(posedge clk50M)
    if (!reset && !sram_ce && !sram_we) mem[sram_addr] <= sram_data;

  always @(negedge clk50M) begin
    if (!reset) begin
      if (!sram_we && !sram_oe) inv_viol++;
      if (!sram_we && !sram_ce) wr_log.push_back({sram_addr, sram_data});
      if (!sram_we) we_cnt++;
      if (!sram_oe) oe_cnt++;
    end
  end

  function automatic logic [15:0] ref_word(input logic [19:0] a);
    return {ref_mem[{a, 1'b1}], ref_mem[{a, 1'b0}]};
  endfunction

  task automatic ref_write(input logic [19:0] a, input logic [15:0] d);
    ref_mem[{a, 1'b0}] = d[7:0];
    ref_mem[{a, 1'b1}] = d[15:8];
  endtask

  task automatic pulse_reset();
    @(negedge clk50M);
    reset = 1'b1;
    repeat (3) @(negedge clk50M);
    reset = 1'b0;
  endtask

  // One word transaction; lat is the ack cycle counted from the grant cycle, -1 on timeout.
  task automatic do_txn(input int p, input logic w, input logic [19:0] a, input logic [15:0] d,
                        output logic [15:0] rd, output int lat);
    @(negedge clk50M);
    if (p == 0) begin we0 = w; addr0 = a; wdata0 = d; req0 = 1'b1; end
    else        begin we1 = w; addr1 = a; wdata1 = d; req1 = 1'b1; end
    lat = -1;
    rd  = '0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk50M);
      if (i == 1) begin
        if (p == 0) begin addr0 = 20'($urandom); wdata0 = 16'($urandom); end
        else        begin addr1 = 20'($urandom); wdata1 = 16'($urandom); end
      end
      vectors++;
      if ((p == 0) ? ack1 : ack0) begin
        miscompares++;
        $display("FAIL stray_ack: port %0d acked during port %0d transaction, required no ack", 1 - p, p);
      end
      if ((p == 0) ? ack0 : ack1) begin
        lat = i;
        rd  = (p == 0) ? rdata0 : rdata1;
        break;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    $display("txn port=%0d we=%0d addr=%05h wdata=%04h rdata=%04h lat=%0d", p, w, a, d, rd, lat);
  endtask

  task automatic test_reset();
    @(negedge clk50M);
    reset = 1'b1;
    repeat (3) @(negedge clk50M);
    vectors += 9;
    if (sram_ce !== 1'b1)     begin miscompares++; $display("FAIL reset_ce: got %b want 1", sram_ce); end
    if (sram_we !== 1'b1)     begin miscompares++; $display("FAIL reset_we: got %b want 1", sram_we); end
    if (sram_oe !== 1'b1)     begin miscompares++; $display("FAIL reset_oe: got %b want 1", sram_oe); end
    if (sram_addr !== 21'h0)  begin miscompares++; $display("FAIL reset_addr: got %h want 0", sram_addr); end
    if (ack0 !== 1'b0)        begin miscompares++; $display("FAIL reset_ack0: got %b want 0", ack0); end
    if (ack1 !== 1'b0)        begin miscompares++; $display("FAIL reset_ack1: got %b want 0", ack1); end
    if (rdata0 !== 16'h0)     begin miscompares++; $display("FAIL reset_rdata0: got %h want 0", rdata0); end
    if (rdata1 !== 16'h0)     begin miscompares++; $display("FAIL reset_rdata1: got %h want 0", rdata1); end
    if (busy !== 1'b0)        begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b0;
    @(negedge clk50M);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_write_p0();
    logic exp_we, exp_lo;
    @(negedge clk50M);
    we0 = 1'b1; addr0 = 20'h00010; wdata0 = 16'hBEEF; req0 = 1'b1;
    for (int k = 1; k <= LAT + 2; k++) begin
      @(negedge clk50M);
      exp_we = !((k >= 2 && k <= W + 1) || (k >= W + 4 && k <= 2 * W + 3));
      exp_lo = (k <= W + 2);
      vectors += 3;
      if (sram_we !== exp_we) begin miscompares++; $display("FAIL wr_we c%0d: got %b want %b", k, sram_we, exp_we); end
      if (busy !== (k <= LAT)) begin miscompares++; $display("FAIL wr_busy c%0d: got %b want %b", k, busy, k <= LAT); end
      if (ack0 !== (k == LAT)) begin miscompares++; $display("FAIL wr_ack0 c%0d: got %b want %b", k, ack0, k == LAT); end
      if (k < LAT) begin
        vectors += 2;
        if (sram_addr !== (exp_lo ? 21'h000020 : 21'h000021)) begin
          miscompares++; $display("FAIL wr_addr c%0d: got %h want %h", k, sram_addr, exp_lo ? 21'h20 : 21'h21);
        end
        if (sram_data !== (exp_lo ? 8'hEF : 8'hBE)) begin
          miscompares++; $display("FAIL wr_data c%0d: got %h want %h", k, sram_data, exp_lo ? 8'hEF : 8'hBE);
        end
      end
      if (k == LAT) req0 = 1'b0;
    end
    ref_write(20'h00010, 16'hBEEF);
  endtask

  task automatic test_read_p1();
    logic [15:0] rd;
    int lat, we0c, oe0c;
    we0c = we_cnt;
    oe0c = oe_cnt;
    do_txn(1, 1'b0, 20'h00010, 16'h0000, rd, lat);
    vectors += 4;
    if (rd !== ref_word(20'h00010)) begin miscompares++; $display("FAIL rd_data: got %h want %h", rd, ref_word(20'h00010)); end
    if (lat != LAT)                 begin miscompares++; $display("FAIL rd_lat: got %0d want %0d", lat, LAT); end
    if (we_cnt != we0c)             begin miscompares++; $display("FAIL rd_we_low: got %0d cycles want 0", we_cnt - we0c); end
    if (oe_cnt - oe0c != 2 * W)     begin miscompares++; $display("FAIL rd_oe_low: got %0d cycles want %0d", oe_cnt - oe0c, 2 * W); end
  endtask

  task automatic test_random();
    logic [15:0] rd, other;
    logic [19:0] a;
    logic [15:0] d;
    logic        w;
    int p, lat;
    for (int n = 0; n < 40; n++) begin
      p = (n < 8) ? (n % 2) : int'($urandom_range(0, 1));
      w = (n < 8) ? 1'b1 : 1'($urandom_range(0, 1));
      a = (n < 8) ? pool[n] : pool[$urandom_range(0, 7)];
      d = 16'($urandom);
      other = (p == 0) ? rdata1 : rdata0;
      if (w) rd = (p == 0) ? rdata0 : rdata1;
      else   rd = ref_word(a);
      begin
        logic [15:0] exp_rd;
        logic [15:0] got;
        exp_rd = rd;
        do_txn(p, w, a, d, got, lat);
        vectors += 3;
        if (lat != LAT) begin miscompares++; $display("FAIL rnd_lat #%0d: got %0d want %0d", n, lat, LAT); end
        if (got !== exp_rd) begin miscompares++; $display("FAIL rnd_rdata #%0d: got %h want %h", n, got, exp_rd); end
        if (((p == 0) ? rdata1 : rdata0) !== other) begin
          miscompares++; $display("FAIL rnd_other_rdata #%0d: got %h want %h", n, (p == 0) ? rdata1 : rdata0, other);
        end
      end
      if (w) ref_write(a, d);
    end
  endtask

  task automatic test_back_to_back();
    logic        w [2];
    logic [19:0] a [2];
    logic [15:0] d [2];
    int n, last, exp_port, p;
    pulse_reset();
    for (int i = 0; i < 2; i++) begin
      w[i] = 1'($urandom_range(0, 1)); a[i] = pool[$urandom_range(0, 7)]; d[i] = 16'($urandom);
    end
    @(negedge clk50M);
    we0 = w[0]; addr0 = a[0]; wdata0 = d[0];
    we1 = w[1]; addr1 = a[1]; wdata1 = d[1];
    req0 = 1'b1; req1 = 1'b1;
    n = 0; last = 0; exp_port = 0;
    for (int c = 1; c <= 80 && n < 4; c++) begin
      @(negedge clk50M);
      vectors++;
      if (ack0 && ack1) begin miscompares++; $display("FAIL b2b_overlap c%0d: got both acks want one", c); end
      if (ack0 || ack1) begin
        p = ack1 ? 1 : 0;
        vectors += 3;
        if (p != exp_port) begin miscompares++; $display("FAIL b2b_order #%0d: got port %0d want %0d", n, p, exp_port); end
        if (c - last != ((n == 0) ? LAT : LAT + 1)) begin
          miscompares++; $display("FAIL b2b_spacing #%0d: got %0d want %0d", n, c - last, (n == 0) ? LAT : LAT + 1);
        end
        if (!w[p] && ((p == 0) ? rdata0 : rdata1) !== ref_word(a[p])) begin
          miscompares++; $display("FAIL b2b_rdata #%0d: got %h want %h", n, (p == 0) ? rdata0 : rdata1, ref_word(a[p]));
        end
        if (w[p]) ref_write(a[p], d[p]);
        $display("txn b2b port=%0d we=%0d addr=%05h cycle=%0d", p, w[p], a[p], c);
        last = c; n++; exp_port = 1 - exp_port;
        w[p] = 1'($urandom_range(0, 1)); a[p] = pool[$urandom_range(0, 7)]; d[p] = 16'($urandom);
        if (p == 0) begin we0 = w[0]; addr0 = a[0]; wdata0 = d[0]; end
        else        begin we1 = w[1]; addr1 = a[1]; wdata1 = d[1]; end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    vectors++;
    if (n != 4) begin miscompares++; $display("FAIL b2b_count: got %0d acks want 4", n); end
  endtask

  task automatic test_top_addr();
    logic [15:0] rd;
    int lat;
    wr_log.delete();
    do_txn(1, 1'b1, 20'hFFFFF, 16'h8001, rd, lat);
    ref_write(20'hFFFFF, 16'h8001);
    vectors++;
    if (wr_log.size() != 2 * W) begin
      miscompares++; $display("FAIL top_wr_cycles: got %0d want %0d", wr_log.size(), 2 * W);
    end else begin
      for (int i = 0; i < 2 * W; i++) begin
        vectors++;
        if (wr_log[i] !== ((i < W) ? {21'h1FFFFE, 8'h01} : {21'h1FFFFF, 8'h80})) begin
          miscompares++;
          $display("FAIL top_wr #%0d: got addr %h data %h want %h", i, wr_log[i][28:8], wr_log[i][7:0],
                   (i < W) ? {21'h1FFFFE, 8'h01} : {21'h1FFFFF, 8'h80});
        end
      end
    end
    do_txn(0, 1'b0, 20'hFFFFF, 16'h0000, rd, lat);
    vectors++;
    if (rd !== 16'h8001) begin miscompares++; $display("FAIL top_readback: got %h want 8001", rd); end
  endtask

  task automatic test_reset_midop();
    logic [15:0] rd;
    int lat, acks;
    @(negedge clk50M);
    we0 = 1'b1; addr0 = 20'h00123; wdata0 = 16'h1234; req0 = 1'b1;
    repeat (3) @(negedge clk50M);
    vectors++;
    if (sram_we !== 1'b0) begin miscompares++; $display("FAIL mid_pre_we: got %b want 0", sram_we); end
    #3 reset = 1'b1;
    #1;
    vectors += 4;
    if (sram_we !== 1'b1) begin miscompares++; $display("FAIL mid_we: got %b want 1", sram_we); end
    if (sram_ce !== 1'b1) begin miscompares++; $display("FAIL mid_ce: got %b want 1", sram_ce); end
    if (sram_oe !== 1'b1) begin miscompares++; $display("FAIL mid_oe: got %b want 1", sram_oe); end
    if (busy !== 1'b0)    begin miscompares++; $display("FAIL mid_busy: got %b want 0", busy); end
    req0 = 1'b0;
    acks = 0;
    repeat (2) begin @(negedge clk50M); if (ack0 || ack1) acks++; end
    reset = 1'b0;
    repeat (14) begin @(negedge clk50M); if (ack0 || ack1) acks++; end
    vectors++;
    if (acks != 0) begin miscompares++; $display("FAIL mid_no_ack: got %0d acks want 0", acks); end
    do_txn(0, 1'b1, 20'h00123, 16'h5A5A, rd, lat);
    ref_write(20'h00123, 16'h5A5A);
    do_txn(1, 1'b0, 20'h00123, 16'h0000, rd, lat);
    vectors += 2;
    if (lat != LAT)      begin miscompares++; $display("FAIL mid_after_lat: got %0d want %0d", lat, LAT); end
    if (rd !== 16'h5A5A) begin miscompares++; $display("FAIL mid_after_rdata: got %h want 5a5a", rd); end
  endtask

  task automatic test_invariants();
    vectors++;
    if (inv_viol != 0) begin miscompares++; $display("FAIL we_oe_both_low: got %0d cycles want 0", inv_viol); end
  endtask

  initial begin
    reset = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    for (int i = 0; i < 8; i++) pool[i] = 20'h00400 + 20'(i * 37);
    test_reset();
    test_write_p0();
    test_read_p1();
    test_random();
    test_back_to_back();
    test_top_addr();
    test_reset_midop();
    test_invariants();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
Shares the single onboard 8-bit asynchronous SRAM between two requesters. Port 0 is the UART data loader; port 1 is the processing datapath. Each requester issues 16-bit word reads or writes, which suit the signed 16-bit number format. The block splits each word into two sequenced byte cycles on the SRAM pins and acknowledges completion. It sits in top_level between the requesters and the sram_data/sram_addr/sram_ce/sram_we/sram_oe pins.

Parameters:
WAIT_CYCLES, 3, number of cycles the strobe (we or oe) is held low per byte; legal values >=1; 3 gives 60 ns at 50 MHz.
ADDR_W, 21, SRAM byte address width; word address width is ADDR_W-1.

Ports:
clk50M  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-high reset
req0  in  1  port 0 request; held high until ack0
we0  in  1  port 0 direction: 1 = write, 0 = read; stable while req0 is high
addr0  in  20  port 0 word address
wdata0  in  16  port 0 write word
ack0  out  1  one-cycle completion pulse for port 0
rdata0  out  16  port 0 read word; valid when ack0 is high, held until the next port 0 read completes
req1, we1, addr1, wdata1, ack1, rdata1: same as port 0, for port 1
busy  out  1  high whenever the FSM is not in IDLE
sram_data  inout  8  SRAM data bus
sram_addr  out  21  SRAM byte address
sram_ce  out  1  chip enable, active-low
sram_we  out  1  write enable, active-low
sram_oe  out  1  output enable, active-low

Behaviour:
- All outputs are registered.
- Reset values:
  - sram_ce=1, sram_we=1, sram_oe=1, sram_addr=0.
  - sram_data is high-Z.
  - ack0=ack1=0, rdata0=rdata1=0, busy=0.
  - last_grant=1, so port 0 wins the first tie.
- FSM states: IDLE, SETUP_LO, STROBE_LO, HOLD_LO, SETUP_HI, STROBE_HI, HOLD_HI, DONE.
- IDLE:
  - All strobes are high and the bus is released.
  - If exactly one req is high, grant it.
  - If both are high, grant the port that was not last_grant.
  - On grant, latch port id, we, addr, and wdata, then go to SETUP_LO.
- SETUP_LO (1 cycle):
  - sram_ce=0, sram_addr={addr,1'b0}.
  - For writes, drive sram_data=wdata[7:0].
- STROBE_LO (WAIT_CYCLES cycles, counter-timed):
  - Write: sram_we=0.
  - Read: sram_oe=0. Capture sram_data into rdata[7:0] on the last cycle.
- HOLD_LO (1 cycle):
  - Strobe returns high.
  - Address, data, and ce are unchanged (gives address/data hold).
- SETUP_HI, STROBE_HI, HOLD_HI: identical to the LO states, with sram_addr={addr,1'b1} and byte wdata[15:8] / rdata[15:8]. Byte order is little-endian.
- DONE (1 cycle):
  - sram_ce=1, bus released.
  - ack of the granted port = 1; the full rdata word is updated for reads.
  - last_grant = the granted port. Then go to IDLE.
- Latency: with the grant cycle as cycle 0, ack is high in cycle 2*WAIT_CYCLES+5 (cycle 11 for default W=3). The next grant is no earlier than cycle 2*W+6.
- Requester contract: deassert req at the clock edge that ends the ack cycle. A req still high in IDLE is treated as a new request.
- Bus drive: sram_data is driven only when the current transaction is a write and the state is SETUP/STROBE/HOLD. It is high-Z in all other states and for reads.
- Invariants:
  - sram_we and sram_oe are never low in the same cycle.
  - sram_we is never low during a read.
  - sram_oe is never low while the bus is driven.
- Requester-side signal changes mid-transaction are ignored; latched copies are used.
- The non-granted port sees no ack and its rdata is unchanged.
- Reset mid-operation: reset acts immediately, not at the next clock edge.
  - Strobes and ce go high, the bus is released.
  - The in-flight transaction is dropped with no ack; the FSM restarts in IDLE.

Test Plan:
- Reset held 3 cycles -> ce/we/oe=1, sram_addr=0, sram_data=Z, ack0/1=0, rdata0/1=0, busy=0.
- Port 0 write, addr0=0x00010, wdata0=0xBEEF, W=3 -> sram_addr=0x000020 with data 0xEF, sram_we low in cycles 2-4; then sram_addr=0x000021 with data 0xBE, sram_we low in cycles 7-9; ack0 high only in cycle 11; busy high in cycles 1-11.
- Port 1 read of 0x00010 against an SRAM model -> sram_oe low, sram_we high throughout, bus never driven by the DUT; rdata1=0xBEEF (-16657) at ack1.
- req0 and req1 both held continuously for 4 transactions after reset -> grant order 0,1,0,1; each ack is exactly one cycle; transactions never overlap.
- Reset asserted during STROBE_LO of a write -> sram_we, sram_ce go high and sram_data goes Z immediately; no ack; after release a fresh req completes normally.
- addr1=0xFFFFF write of 0x8001 -> bytes 0x01 at 0x1FFFFE and 0x80 at 0x1FFFFF; no other addresses are touched.
